// File: rtl/cla_sweep_checker.sv
// Exhaustive sweep engine for a carry look-ahead adder: drives every
// {cin, B, A}, compares {cout, S} against a reference sum, reports the result.
module cla_sweep_checker #(
   parameter int WIDTH = 4,
   parameter int LAT   = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic [WIDTH-1:0]     a_o,
   output logic [WIDTH-1:0]     b_o,
   output logic                 cin_o,
   input  logic [WIDTH-1:0]     s_i,
   input  logic                 cout_i,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2*WIDTH+1:0]   err_count,
   output logic [2*WIDTH:0]     first_fail
);

   localparam int VW = 2*WIDTH+1;
   localparam int EW = WIDTH+1;
   localparam int CW = 2*WIDTH+2;
   localparam logic [CW-1:0] C_ONE = 1;
   localparam logic [VW-1:0] V_ONE = 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t          r_state;
   logic            r_start;
   logic [VW-1:0]   r_vec;
   logic [2:0]      r_drain;
   logic            r_busy;
   logic            r_done;
   logic [CW-1:0]   r_err;
   logic [VW-1:0]   r_ff;

   logic            w_issue;
   logic [EW-1:0]   w_exp;
   logic            w_tap_v;
   logic [VW-1:0]   w_tap_vec;
   logic [EW-1:0]   w_tap_exp;
   logic            w_mis;

   assign w_issue = (r_state == S_RUN);
   assign w_exp   = {1'b0, r_vec[WIDTH-1:0]}
                  + {1'b0, r_vec[2*WIDTH-1:WIDTH]}
                  + EW'(r_vec[VW-1]);

   generate
      if (LAT == 0) begin : g_comb
         assign w_tap_v   = w_issue;
         assign w_tap_vec = r_vec;
         assign w_tap_exp = w_exp;
      end else begin : g_pipe
         // Reference data follows the adder's pipeline; only valid is reset.
         logic [LAT-1:0] r_v;
         logic [VW-1:0]  r_pv [LAT];
         logic [EW-1:0]  r_pe [LAT];

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_v <= '0;
            end else begin
               r_v[0] <= w_issue;
               for (int i = 1; i < LAT; i++) begin
                  r_v[i] <= r_v[i-1];
               end
            end
         end

         always_ff @(posedge clk) begin
            r_pv[0] <= r_vec;
            r_pe[0] <= w_exp;
            for (int i = 1; i < LAT; i++) begin
               r_pv[i] <= r_pv[i-1];
               r_pe[i] <= r_pe[i-1];
            end
         end

         assign w_tap_v   = r_v[LAT-1];
         assign w_tap_vec = r_pv[LAT-1];
         assign w_tap_exp = r_pe[LAT-1];
      end
   endgenerate

   assign w_mis = w_tap_v && ({cout_i, s_i} != w_tap_exp);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_start <= 1'b0;
         r_vec   <= '0;
         r_drain <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= '0;
         r_ff    <= '0;
      end else begin
         r_start <= start;
         if (w_mis) begin
            r_err <= r_err + C_ONE;
            if (r_err == '0) r_ff <= w_tap_vec;
         end
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (r_start) begin
                  r_state <= S_RUN;
                  r_vec   <= '0;
                  r_err   <= '0;
                  r_ff    <= '0;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            S_RUN: begin
               r_vec <= r_vec + V_ONE;
               if (r_vec == '1) begin
                  if (LAT > 0) begin
                     r_state <= S_DRAIN;
                     r_drain <= '0;
                  end else begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               r_drain <= r_drain + 3'd1;
               if (r_drain == 3'(LAT-1)) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign a_o        = r_vec[WIDTH-1:0];
   assign b_o        = r_vec[2*WIDTH-1:WIDTH];
   assign cin_o      = r_vec[VW-1];
   assign busy       = r_busy;
   assign done       = r_done;
   assign pass       = r_done && (r_err == '0);
   assign err_count  = r_err;
   assign first_fail = r_ff;

endmodule
